ervp_fifo_packer: RTL

Downstream consumer of the small FIFO's read port. It pops narrow words of BW_DATA bits and packs NUM_WORD of them into one wide word. The wide word is presented on a write-style port (wready/wrequest/wdata) that can feed a wider FIFO or a bus-write stage. A flush request emits a partially filled word, with the valid-word count reported alongside.

---
 rtl/ervp_fifo_packer_if.sv | 27 ++
 rtl/ervp_fifo_packer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ervp_fifo_packer_if.sv
// Handshake bundle between the narrow-word FIFO read port and the wide-word
// write port of ervp_fifo_packer.
interface ervp_fifo_packer_if #(
    parameter int BW_DATA  = 8,
    parameter int NUM_WORD = 4,
    parameter int BW_COUNT = $clog2(NUM_WORD + 1)
);
    logic                        rready;
    logic                        rrequest;
    logic [BW_DATA-1:0]          rdata;
    logic                        wready;
    logic                        wrequest;
    logic [BW_DATA*NUM_WORD-1:0] wdata;
    logic [BW_COUNT-1:0]         wcount;

    // packer side: pops narrow words, presents packed words
    modport master (
        input  rready, rdata, wready,
        output rrequest, wrequest, wdata, wcount
    );

    // environment side: upstream FIFO plus downstream sink
    modport slave (
        output rready, rdata, wready,
        input  rrequest, wrequest, wdata, wcount
    );
endinterface

// File: rtl/ervp_fifo_packer.sv
// Packs NUM_WORD narrow words popped from a small FIFO into one wide word.
// A flush emits a partial word; wcount reports how many slots are valid.
// The emitting HOLD cycle may also pop, so a full stream runs without bubbles.
module ervp_fifo_packer #(
    parameter int BW_DATA   = 8,
    parameter int NUM_WORD  = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               enable,
    input  logic               clear,
    input  logic               flush,
    ervp_fifo_packer_if.master bus
);
    localparam int BW_COUNT = $clog2(NUM_WORD + 1);
    localparam int BW_PACK  = BW_DATA * NUM_WORD;
    localparam logic [BW_COUNT-1:0] COUNT_FULL = BW_COUNT'(NUM_WORD);
    localparam logic [BW_COUNT-1:0] COUNT_ONE  = BW_COUNT'(1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [BW_COUNT-1:0] count_r;
    logic [BW_COUNT-1:0] count_nx_s;
    logic [BW_PACK-1:0]  pack_r;
    logic [BW_PACK-1:0]  pack_nx_s;
    logic                active_s;
    logic                in_fire_s;
    logic                out_fire_s;

    // Drop a word into the slot belonging to the k-th accepted word.
    function automatic logic [BW_PACK-1:0] place_word(
        input logic [BW_PACK-1:0]  base,
        input logic [BW_COUNT-1:0] k,
        input logic [BW_DATA-1:0]  word
    );
        logic [BW_PACK-1:0] res;
        int                 slot;
        res  = base;
        slot = (LSB_FIRST != 0) ? int'(k) : (NUM_WORD - 1 - int'(k));
        for (int s = 0; s < NUM_WORD; s++) begin
            if (s == slot) begin
                res[s*BW_DATA +: BW_DATA] = word;
            end
        end
        return res;
    endfunction

    assign active_s   = enable & ~clear;
    assign in_fire_s  = active_s & bus.rready &
                        ((state_r == FILL) | ((state_r == HOLD) & bus.wready));
    assign out_fire_s = active_s & (state_r == HOLD) & bus.wready;

    assign bus.rrequest = in_fire_s;
    assign bus.wrequest = active_s & (state_r == HOLD);
    assign bus.wdata    = pack_r;
    assign bus.wcount   = count_r;

    // Next-state: fill slots, close the word on full or flush, drain on handshake.
    always_comb begin
        state_nx_s = state_r;
        count_nx_s = count_r;
        pack_nx_s  = pack_r;
        if (!enable) begin
            state_nx_s = state_r;
        end else if (clear) begin
            state_nx_s = FILL;
            count_nx_s = '0;
            pack_nx_s  = '0;
        end else begin
            case (state_r)
                FILL: begin
                    if (in_fire_s) begin
                        pack_nx_s  = place_word(pack_r, count_r, bus.rdata);
                        count_nx_s = count_r + COUNT_ONE;
                    end else begin
                        count_nx_s = count_r;
                    end
                    // flush counts the word popped this same cycle
                    if (count_nx_s == COUNT_FULL) begin
                        state_nx_s = HOLD;
                    end else if (flush && (count_nx_s != '0)) begin
                        state_nx_s = HOLD;
                    end else begin
                        state_nx_s = FILL;
                    end
                end
                HOLD: begin
                    if (out_fire_s && in_fire_s) begin
                        pack_nx_s  = place_word('0, '0, bus.rdata);
                        count_nx_s = COUNT_ONE;
                        state_nx_s = (NUM_WORD == 1) ? HOLD : FILL;
                    end else if (out_fire_s) begin
                        pack_nx_s  = '0;
                        count_nx_s = '0;
                        state_nx_s = FILL;
                    end else begin
                        state_nx_s = HOLD;
                    end
                end
                default: begin
                    state_nx_s = FILL;
                    count_nx_s = '0;
                    pack_nx_s  = '0;
                end
            endcase
        end
    end

    // State, fill count and pack register; reset discards any partial word.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_r <= FILL;
            count_r <= '0;
            pack_r  <= '0;
        end else begin
            state_r <= state_nx_s;
            count_r <= count_nx_s;
            pack_r  <= pack_nx_s;
        end
    end
endmodule
